// File: rtl/trigonometric_unit.sv
// Fixed-point sine/cosine of an angle in tenths of a degree, 3-register pipeline.
// Quarter-wave 1-degree table with rounded linear interpolation of the tenths.
module trigonometric_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] degree,
   input  logic        iscos,
   output logic [9:0]  value
);

   // round(511 * sin(i deg)) for i = 0..90
   function automatic logic [8:0] sin_tab(input logic [6:0] idx);
      logic [8:0] t;
      t = 9'd0;
      case (idx)
         7'd0:  t = 9'd0;
         7'd1:  t = 9'd9;
         7'd2:  t = 9'd18;
         7'd3:  t = 9'd27;
         7'd4:  t = 9'd36;
         7'd5:  t = 9'd45;
         7'd6:  t = 9'd53;
         7'd7:  t = 9'd62;
         7'd8:  t = 9'd71;
         7'd9:  t = 9'd80;
         7'd10: t = 9'd89;
         7'd11: t = 9'd98;
         7'd12: t = 9'd106;
         7'd13: t = 9'd115;
         7'd14: t = 9'd124;
         7'd15: t = 9'd132;
         7'd16: t = 9'd141;
         7'd17: t = 9'd149;
         7'd18: t = 9'd158;
         7'd19: t = 9'd166;
         7'd20: t = 9'd175;
         7'd21: t = 9'd183;
         7'd22: t = 9'd191;
         7'd23: t = 9'd200;
         7'd24: t = 9'd208;
         7'd25: t = 9'd216;
         7'd26: t = 9'd224;
         7'd27: t = 9'd232;
         7'd28: t = 9'd240;
         7'd29: t = 9'd248;
         7'd30: t = 9'd256;
         7'd31: t = 9'd263;
         7'd32: t = 9'd271;
         7'd33: t = 9'd278;
         7'd34: t = 9'd286;
         7'd35: t = 9'd293;
         7'd36: t = 9'd300;
         7'd37: t = 9'd308;
         7'd38: t = 9'd315;
         7'd39: t = 9'd322;
         7'd40: t = 9'd328;
         7'd41: t = 9'd335;
         7'd42: t = 9'd342;
         7'd43: t = 9'd349;
         7'd44: t = 9'd355;
         7'd45: t = 9'd361;
         7'd46: t = 9'd368;
         7'd47: t = 9'd374;
         7'd48: t = 9'd380;
         7'd49: t = 9'd386;
         7'd50: t = 9'd391;
         7'd51: t = 9'd397;
         7'd52: t = 9'd403;
         7'd53: t = 9'd408;
         7'd54: t = 9'd413;
         7'd55: t = 9'd419;
         7'd56: t = 9'd424;
         7'd57: t = 9'd429;
         7'd58: t = 9'd433;
         7'd59: t = 9'd438;
         7'd60: t = 9'd443;
         7'd61: t = 9'd447;
         7'd62: t = 9'd451;
         7'd63: t = 9'd455;
         7'd64: t = 9'd459;
         7'd65: t = 9'd463;
         7'd66: t = 9'd467;
         7'd67: t = 9'd470;
         7'd68: t = 9'd474;
         7'd69: t = 9'd477;
         7'd70: t = 9'd480;
         7'd71: t = 9'd483;
         7'd72: t = 9'd486;
         7'd73: t = 9'd489;
         7'd74: t = 9'd491;
         7'd75: t = 9'd494;
         7'd76: t = 9'd496;
         7'd77: t = 9'd498;
         7'd78: t = 9'd500;
         7'd79: t = 9'd502;
         7'd80: t = 9'd503;
         7'd81: t = 9'd505;
         7'd82: t = 9'd506;
         7'd83: t = 9'd507;
         7'd84: t = 9'd508;
         7'd85: t = 9'd509;
         7'd86: t = 9'd510;
         7'd87: t = 9'd510;
         7'd88: t = 9'd511;
         7'd89: t = 9'd511;
         7'd90: t = 9'd511;
         default: t = 9'd0;
      endcase
      return t;
   endfunction

   // Stage 1: range reduction, cosine phase shift and quadrant folding
   logic [11:0] red_deg;
   logic [12:0] shifted;
   logic [11:0] ang;
   logic [11:0] fold;
   logic [9:0]  mag_d, mag_q;
   logic        neg1_d, neg1_q;

   always_comb begin
      red_deg = (degree >= 12'd3600) ? degree - 12'd3600 : degree;
      shifted = {1'b0, red_deg} + 13'd900;
      ang     = red_deg;
      if (iscos) begin
         ang = (shifted >= 13'd3600) ? 12'(shifted - 13'd3600) : shifted[11:0];
      end
      fold   = ang;
      neg1_d = 1'b0;
      if (ang < 12'd900) begin
         fold = ang;
      end else if (ang < 12'd1800) begin
         fold = 12'd1800 - ang;
      end else if (ang < 12'd2700) begin
         fold   = ang - 12'd1800;
         neg1_d = 1'b1;
      end else begin
         fold   = 12'd3600 - ang;
         neg1_d = 1'b1;
      end
      mag_d = 10'(fold);
   end

   // Stage 2: split into whole degrees and tenths, fetch the two neighbouring entries
   logic [6:0] idx, idx_hi;
   logic [3:0] frac_d, frac_q;
   logic [8:0] lo_d, lo_q, hi;
   logic [3:0] diff_d, diff_q;
   logic       neg2_q;

   always_comb begin
      idx    = 7'(mag_q / 10'd10);
      frac_d = 4'(mag_q % 10'd10);
      idx_hi = (idx == 7'd90) ? idx : idx + 7'd1;
      lo_d   = sin_tab(idx);
      hi     = sin_tab(idx_hi);
      // Sine is monotonic on the quarter wave, so the step is never negative
      diff_d = 4'(hi - lo_d);
   end

   // Stage 3: interpolate with round-to-nearest, then apply the quadrant sign
   logic [7:0] prod;
   logic [3:0] step;
   logic [9:0] mag;
   logic [9:0] value_d, value_q;

   always_comb begin
      prod    = {4'd0, diff_q} * {4'd0, frac_q};
      step    = 4'((prod + 8'd5) / 8'd10);
      mag     = {1'b0, lo_q} + {6'd0, step};
      value_d = neg2_q ? (~mag + 10'd1) : mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mag_q   <= '0;
         neg1_q  <= 1'b0;
         lo_q    <= '0;
         diff_q  <= '0;
         frac_q  <= '0;
         neg2_q  <= 1'b0;
         value_q <= '0;
      end else begin
         mag_q   <= mag_d;
         neg1_q  <= neg1_d;
         lo_q    <= lo_d;
         diff_q  <= diff_d;
         frac_q  <= frac_d;
         neg2_q  <= neg1_q;
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: tb/tb_trigonometric_unit.sv
// Bench for trigonometric_unit: vector table, iscos toggle, full sweep with mid-stream reset.
// Expected results queue up as inputs are driven and are retired when the output is due.
module tb_trigonometric_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] degree;
   logic        iscos;
   logic [9:0]  value;

   always #5 clk = ~clk;

   trigonometric_unit dut (
      .clk    (clk),
      .rst    (rst),
      .degree (degree),
      .iscos  (iscos),
      .value  (value)
   );

   typedef struct {
      int deg;
      bit cos;
      int exp;
      int tol;
   } vec_t;

   typedef struct {
      bit    chk;
      int    exp;
      int    tol;
      string name;
   } exp_t;

   localparam int Lag = 3;

   exp_t sb[$];
   vec_t vecs[16];
   int   checks = 0;
   int   errors = 0;

   function automatic int ideal(int deg, bit c);
      real pi = 3.14159265358979;
      int  d;
      real th;
      real r;
      d  = (deg >= 3600) ? deg - 3600 : deg;
      th = d / 10.0 + (c ? 90.0 : 0.0);
      r  = 511.0 * $sin(th * pi / 180.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(-r + 0.5);
   endfunction

   task automatic compare(input exp_t e);
      int act;
      int d;
      act = int'($signed(value));
      d   = act - e.exp;
      if (d < 0) d = -d;
      checks++;
      if (d > e.tol) begin
         errors++;
         $display("FAIL %s: value=%0d expected %0d (+/-%0d)", e.name, act, e.exp, e.tol);
      end
   endtask

   // One cycle: retire the result due now, then drive the next inputs
   task automatic step(input bit r, input int deg, input bit c, input int exp, input int tol,
                       input bit chk, input string name);
      exp_t e;
      exp_t z;
      @(negedge clk);
      if (sb.size() == Lag) begin
         e = sb.pop_front();
         if (e.chk) compare(e);
      end
      rst    = r;
      degree = 12'(deg);
      iscos  = c;
      if (r) begin
         // Reset wipes everything still in flight
         for (int i = 0; i < sb.size(); i++) begin
            z      = sb[i];
            z.chk  = 1'b1;
            z.exp  = 0;
            z.tol  = 0;
            z.name = {z.name, "_flushed"};
            sb[i]  = z;
         end
      end
      e.chk  = chk;
      e.exp  = r ? 0 : exp;
      e.tol  = r ? 0 : tol;
      e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      rst    = 1'b1;
      degree = '0;
      iscos  = 1'b0;

      vecs = '{
         '{800,  1'b0,  503, 1}, '{1000, 1'b0,  503, 1}, '{1100, 1'b0,  480, 1},
         '{1700, 1'b0,   89, 1}, '{800,  1'b1,   89, 1}, '{1000, 1'b1,  -89, 1},
         '{1100, 1'b1, -175, 1}, '{1700, 1'b1, -503, 1}, '{900,  1'b0,  511, 0},
         '{2700, 1'b0, -511, 0}, '{0,    1'b1,  511, 0}, '{1800, 1'b1, -511, 0},
         '{1800, 1'b0,    0, 0}, '{3600, 1'b0,    0, 0}, '{4095, 1'b0,  389, 1},
         '{0,    1'b0,    0, 0}
      };

      step(1'b1, 0, 1'b0, 0, 0, 1'b1, "reset_0");
      step(1'b1, 0, 1'b0, 0, 0, 1'b1, "reset_1");
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, "zero_after_reset");

      for (int i = 0; i < 16; i++) begin
         step(1'b0, vecs[i].deg, vecs[i].cos, vecs[i].exp, vecs[i].tol, 1'b1,
              $sformatf("vec%0d_deg%0d_cos%0d", i, vecs[i].deg, vecs[i].cos));
      end

      // Same angle, only the function select changes
      step(1'b0, 300, 1'b0, 256, 1, 1'b1, "toggle_sin300_a");
      step(1'b0, 300, 1'b1, 443, 1, 1'b1, "toggle_cos300");
      step(1'b0, 300, 1'b0, 256, 1, 1'b1, "toggle_sin300_b");
      step(1'b0, 4095, 1'b1, ideal(495, 1'b1), 1, 1'b1, "wrap_cos4095");

      for (int c = 0; c < 2; c++) begin
         for (int d = 0; d < 3600; d++) begin
            if (c == 0 && d == 1800) begin
               step(1'b1, d, 1'b0, 0, 0, 1'b1, "mid_reset_0");
               step(1'b1, d, 1'b0, 0, 0, 1'b1, "mid_reset_1");
            end
            step(1'b0, d, c[0], ideal(d, c[0]), 1, 1'b1,
                 $sformatf("sweep_deg%0d_cos%0d", d, c));
         end
      end

      for (int i = 0; i < Lag; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, "drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
